prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter AW, default 6, meaning word-address width, with clog2(DEPTH) <= AW.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  byte stream valid.
REQ-006 SHALL have port in_data  input  8  byte stream data.
REQ-007 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port wr_addr  output  AW  word index being written.
REQ-010 SHALL have port wr_data  output  32  word being written.
REQ-011 SHALL have port cpu_reset  output  1  holds the core in reset while 1.
REQ-012 SHALL have port done  output  1  image loaded; core released.
REQ-013 SHALL have port err  output  1  load failed; sticky until reset.

Function
REQ-014 SHALL accept a byte on each rising edge where in_valid && in_ready; no byte is consumed otherwise.
REQ-015 SHALL implement states LEN_LO, LEN_HI, DATA, CHK (CHECKSUM_EN only), DONE and ERR.
REQ-016 SHALL interpret the stream as: 16-bit word count N (low byte first), then N words, each 4 bytes, little-endian (first byte -> bits 7:0).
REQ-017 SHALL move LEN_LO->LEN_HI on acceptance; on LEN_HI acceptance go to ERR if N > DEPTH, else DATA if N > 0, else CHK/DONE.
REQ-018 SHALL, on acceptance of the 4th byte of word k, pulse wr_en for exactly the next cycle, with wr_addr = k and wr_data = the assembled word; wr_addr/wr_data hold their last values when wr_en = 0.
REQ-019 SHALL leave DATA after acceptance of byte 4N, going to CHK (macro defined) or DONE.
REQ-020 SHALL drive in_ready = 1 in LEN_LO, LEN_HI, DATA, CHK and ERR (ERR drains and discards input), and 0 in DONE.
REQ-021 SHALL raise done and drop cpu_reset on the second rising edge after acceptance of the final stream byte, so the final wr_en pulse always precedes release of the core.
REQ-022 SHALL, in DONE, ignore all input and keep done = 1, cpu_reset = 0 until reset.
REQ-023 SHALL, in ERR, hold err = 1, done = 0, cpu_reset = 1, wr_en = 0 until reset.
REQ-024 SHALL treat in_valid held low mid-word as a stall: partial-word bytes are kept, no timeout.
REQ-025 SHALL never write addresses >= N, and SHALL wrap no counter.

Reset
REQ-026 SHALL, while reset = 1 (asynchronously), force state LEN_LO, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_reset = 1, done = 0, err = 0, in_ready = 0.
REQ-027 SHALL drive in_ready = 1 from the first rising edge after reset deasserts.
REQ-028 SHALL abandon any partial load on reset mid-operation; already-written words are not undone, and the next load restarts from LEN_LO.

Configuration
REQ-029 SHALL, with CHECKSUM_EN defined, expect one trailing byte in state CHK, such that the 8-bit sum mod 256 of all stream bytes (length, data, checksum) equals 0x00; on match go to DONE, else go to ERR.
REQ-030 SHALL, without CHECKSUM_EN, omit state CHK and running sum, entering DONE directly after the final data byte (or LEN_HI when N = 0).

Verification
REQ-031 Bench SHALL stream 02 00 13 00 00 00 93 00 10 00 with in_valid constantly high -> wr_en pulses writing addr 0 = 0x00000013 and addr 1 = 0x00100093; done = 1 and cpu_reset = 0 two edges after the last byte.
REQ-032 Bench SHALL stream 41 00 (N = 65, DEPTH = 64) -> err = 1, no wr_en pulse, cpu_reset stays 1, in_ready stays 1.
REQ-033 Bench SHALL stream 01 00 followed by bytes EF BE AD DE, with in_valid dropped for 3 cycles between each byte -> a single wr_en pulse, addr 0 = 0xDEADBEEF, no extra writes.
REQ-034 Bench SHALL stream 00 00 without the macro -> done = 1 with zero writes; with the macro, stream 00 00 00 -> done, and 00 00 05 -> err.
REQ-035 With CHECKSUM_EN, bench SHALL stream 01 00 01 00 00 00 FE -> write 0x00000001 then done; changing the last byte to FF -> err = 1 after the write.
REQ-036 Bench SHALL assert reset after 2 of 4 bytes of word 0, then stream a full 1-word image -> only the new word is written at addr 0, and done asserts.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream boot loader that fills instruction memory and then releases the core
// Defining CHECKSUM_EN adds a trailing checksum byte that must bring the 8-bit stream sum to zero.
module prog_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] widx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        release_q;
`ifdef CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        accept;
  logic [15:0] n_in;

  assign accept = in_valid && in_ready;
  assign n_in   = {in_data, len_lo};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= LEN_LO;
      len_lo    <= 8'h00;
      n_words   <= 16'h0000;
      widx      <= 16'h0000;
      byte_cnt  <= 2'd0;
      word_buf  <= 24'h000000;
      release_q <= 1'b0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'h00000000;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      wr_en    <= 1'b0;
      in_ready <= 1'b1;
`ifdef CHECKSUM_EN
      if (accept) sum <= sum + in_data;
`endif
      case (state)
        LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            n_words <= n_in;
            if (n_in > 16'(DEPTH)) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (n_in != 16'd0) begin
              state <= DATA;
            end else begin
`ifdef CHECKSUM_EN
              state    <= CHK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    word_buf[7:0]   <= in_data;
              2'd1:    word_buf[15:8]  <= in_data;
              2'd2:    word_buf[23:16] <= in_data;
              default: begin
                wr_en   <= 1'b1;
                wr_addr <= widx[AW-1:0];
                wr_data <= {in_data, word_buf};
                widx    <= widx + 16'd1;
                if (widx + 16'd1 == n_words) begin
`ifdef CHECKSUM_EN
                  state    <= CHK;
`else
                  state    <= DONE;
                  in_ready <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (sum + in_data == 8'h00) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        // release_q delays release by one more edge so the last write lands first
        DONE: begin
          in_ready  <= 1'b0;
          release_q <= 1'b1;
          if (release_q) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end
        end
        ERR: begin
          err <= 1'b1;
        end
        default: begin
          state <= ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed and randomized checks of prog_loader against a stream-level reference model
// Honours CHECKSUM_EN the same way the design does.
module tb_prog_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef logic [7:0] bq_t[$];

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_reset;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_edge = -1;
  logic [AW-1:0] ga[$];
  logic [31:0]   gd[$];
  int            acc_edge[$];
  int            exp_a[$];
  logic [31:0]   exp_d[$];
  int            exp_out;
  int            exp_last;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      ga.push_back(wr_addr);
      gd.push_back(wr_data);
    end
    if (done === 1'b1 && done_edge < 0) done_edge = cyc;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t mk(input logic [127:0] v, input int cnt);
    bq_t r;
    for (int i = 0; i < cnt; i++) r.push_back(v[8*(cnt-1-i) +: 8]);
    return r;
  endfunction

  function automatic bq_t with_ck(input bq_t s);
    bq_t r;
`ifdef CHECKSUM_EN
    logic [7:0] sm;
    sm = 8'h00;
    foreach (s[i]) sm = sm + s[i];
`endif
    r = s;
`ifdef CHECKSUM_EN
    r.push_back(8'h00 - sm);
`endif
    return r;
  endfunction

  // Outcome: 0 = still loading, 1 = core released, 2 = load failed.
  task automatic predict(input bq_t s);
    int n;
    int last;
    exp_a.delete();
    exp_d.delete();
    exp_out  = 0;
    exp_last = -1;
    if (s.size() < 2) return;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > DEPTH) begin
      exp_out = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (5 + 4*k >= s.size()) return;
      exp_a.push_back(k);
      exp_d.push_back({s[5+4*k], s[4+4*k], s[3+4*k], s[2+4*k]});
    end
    last = 2 + 4*n;
`ifdef CHECKSUM_EN
    begin
      int sm;
      if (s.size() <= last) return;
      sm = 0;
      for (int i = 0; i <= last; i++) sm += int'(s[i]);
      exp_out  = (sm % 256 == 0) ? 1 : 2;
      exp_last = last;
    end
`else
    exp_out  = 1;
    exp_last = last - 1;
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk({tag, "_rst_in_ready"}, in_ready, 0);
    chk({tag, "_rst_wr_en"}, wr_en, 0);
    chk({tag, "_rst_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_rst_wr_data"}, wr_data, 0);
    chk({tag, "_rst_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_rst_done"}, done, 0);
    chk({tag, "_rst_err"}, err, 0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk({tag, "_post_rst_in_ready"}, in_ready, 1);
  endtask

  task automatic send(input bq_t s, input int gmin, input int gmax);
    int w;
    int bound;
    acc_edge.delete();
    foreach (s[i]) begin
      w = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      in_valid = 1'b0;
      repeat (w) @(negedge CLK);
      in_valid = 1'b1;
      in_data  = s[i];
      bound = 0;
      while (in_ready !== 1'b1 && bound < 20) begin
        @(negedge CLK);
        bound++;
      end
      if (bound >= 20) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      acc_edge.push_back(cyc + 1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_case(input string tag, input bq_t s, input int gmin, input int gmax);
    int nw;
    do_reset(tag);
    ga.delete();
    gd.delete();
    done_edge = -1;
    predict(s);
    send(s, gmin, gmax);
    repeat (6) @(negedge CLK);
    chk({tag, "_wr_cnt"}, ga.size(), exp_d.size());
    foreach (exp_d[i]) begin
      chk($sformatf("%s_addr%0d", tag, i), (i < ga.size()) ? 32'(ga[i]) : 32'hxxxxxxxx, exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), (i < gd.size()) ? gd[i] : 32'hxxxxxxxx, exp_d[i]);
    end
    chk({tag, "_done"}, done, exp_out == 1);
    chk({tag, "_err"}, err, exp_out == 2);
    chk({tag, "_cpu_reset"}, cpu_reset, exp_out != 1);
    chk({tag, "_in_ready"}, in_ready, exp_out != 1);
    if (exp_out == 1) begin
      chk({tag, "_done_edge"}, done_edge,
          (exp_last >= 0 && exp_last < acc_edge.size()) ? acc_edge[exp_last] + 2 : -1);
      nw = ga.size();
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (4) @(negedge CLK);
      in_valid = 1'b0;
      chk({tag, "_ignore_wr"}, ga.size(), nw);
      chk({tag, "_hold_done"}, done, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
  endtask

  initial begin
    bq_t s;
    int  n;

    run_case("two_words", with_ck(mk(80'h02_00_13_00_00_00_93_00_10_00, 10)), 0, 0);
    chk("two_words_w0", (gd.size() > 0) ? gd[0] : 32'hxxxxxxxx, 32'h00000013);
    chk("two_words_w1", (gd.size() > 1) ? gd[1] : 32'hxxxxxxxx, 32'h00100093);

    run_case("too_long", mk(40'h41_00_11_22_33, 5), 0, 0);

    run_case("stall", with_ck(mk(48'h01_00_EF_BE_AD_DE, 6)), 3, 3);
    chk("stall_w0", (gd.size() > 0) ? gd[0] : 32'hxxxxxxxx, 32'hDEADBEEF);

`ifdef CHECKSUM_EN
    run_case("empty_ok", mk(24'h00_00_00, 3), 0, 0);
    run_case("empty_bad", mk(24'h00_00_05, 3), 0, 0);
    run_case("ck_ok", mk(56'h01_00_01_00_00_00_FE, 7), 0, 0);
    chk("ck_ok_w0", (gd.size() > 0) ? gd[0] : 32'hxxxxxxxx, 32'h00000001);
    run_case("ck_bad", mk(56'h01_00_01_00_00_00_FF, 7), 0, 0);
    chk("ck_bad_w0", (gd.size() > 0) ? gd[0] : 32'hxxxxxxxx, 32'h00000001);
`else
    run_case("empty", mk(16'h00_00, 2), 0, 0);
`endif

    do_reset("partial");
    ga.delete();
    gd.delete();
    send(mk(32'h01_00_AA_BB, 4), 0, 0);
    repeat (3) @(negedge CLK);
    chk("partial_wr_cnt", ga.size(), 0);
    run_case("reload", with_ck(mk(48'h01_00_78_56_34_12, 6)), 0, 1);
    chk("reload_w0", (gd.size() > 0) ? gd[0] : 32'hxxxxxxxx, 32'h12345678);

    s.delete();
    s.push_back(8'(DEPTH));
    s.push_back(8'(DEPTH >> 8));
    for (int i = 0; i < 4*DEPTH; i++) s.push_back(8'($urandom));
    run_case("full_depth", with_ck(s), 0, 0);

    for (int c = 0; c < 12; c++) begin
      n = (c == 7) ? DEPTH + 1 + int'($urandom_range(2, 0)) : int'($urandom_range(6, 0));
      s.delete();
      s.push_back(n[7:0]);
      s.push_back(n[15:8]);
      if (n <= DEPTH)
        for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
      s = with_ck(s);
`ifdef CHECKSUM_EN
      if ($urandom_range(3, 0) == 0) s[s.size()-1] = s[s.size()-1] ^ 8'h01;
`endif
      run_case($sformatf("rand%0d", c), s, 0, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
